local_mem_responder: RTL and testbench
======================================

LOCAL_MEM_RESPONDER -- requirements
Module: local_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, meaning log2 of the number of cache lines stored (64 lines).
REQ-002 SHALL have parameter DATA_WIDTH, default 512, meaning cache-line width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 req_valid  input  1  requester presents a request.
REQ-006 req_write  input  1  1 = write, 0 = read; qualified by req_valid.
REQ-007 req_addr  input  ADDR_WIDTH  cache-line index.
REQ-008 req_data  input  DATA_WIDTH  write data; ignored for reads.
REQ-009 req_ready  output  1  responder accepts a request this cycle.
REQ-010 rsp_valid  output  1  response presented.
REQ-011 rsp_write  output  1  1 = write acknowledge, 0 = read data.
REQ-012 rsp_data  output  DATA_WIDTH  read data; all-zero for write acknowledges.
REQ-013 rsp_ready  input  1  requester consumes the response this cycle.
REQ-014 init_done  output  1  storage cleared; requests may be issued.
REQ-015 rd_count  output  16  number of accepted reads, saturating.
REQ-016 wr_count  output  16  number of accepted writes, saturating.

Function
REQ-017 SHALL implement states INIT, IDLE, READ_WAIT, RESP.
REQ-018 INIT: a line counter starting at 0 SHALL write all-zero to one line per cycle; after line 2^ADDR_WIDTH-1 is written, the block SHALL go to IDLE.
REQ-019 init_done SHALL be 0 in INIT and 1 in every other state; it SHALL rise exactly 2^ADDR_WIDTH cycles after reset deassertion.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a rising edge.
REQ-021 Accepted write: req_data SHALL be stored at req_addr on the accepting edge; the next state SHALL be RESP with rsp_write=1 and rsp_data=0, so rsp_valid rises 1 cycle after accept.
REQ-022 Accepted read: the storage SHALL be read synchronously; the next state SHALL be READ_WAIT for exactly 1 cycle, then RESP with rsp_write=0 and rsp_data equal to the line contents at accept time, so rsp_valid rises 2 cycles after accept.
REQ-023 RESP: rsp_valid SHALL be 1; rsp_write and rsp_data SHALL be held stable until rsp_ready=1 on a rising edge, after which the next state SHALL be IDLE.
REQ-024 No request SHALL be accepted in RESP or READ_WAIT, including the cycle in which rsp_ready completes the handshake (maximum throughput: one write per 2 cycles, one read per 3 cycles).
REQ-025 rsp_valid SHALL be 0 in INIT, IDLE and READ_WAIT.
REQ-026 req_valid while init_done=0 SHALL be ignored and SHALL NOT change storage or counters.
REQ-027 rd_count / wr_count SHALL increment by 1 on each accepted read / write and SHALL hold at 16'hFFFF instead of wrapping.
REQ-028 Addresses SHALL cover exactly 0 to 2^ADDR_WIDTH-1; lines 0 and 2^ADDR_WIDTH-1 SHALL be independent storage.
REQ-029 Request inputs SHALL be sampled only on the accepting edge; changes in later cycles SHALL NOT affect the pending response.

Reset
REQ-030 While rst_n=0: state=INIT, line counter=0, req_ready=0, rsp_valid=0, rsp_write=0, rsp_data=0, init_done=0, rd_count=0, wr_count=0.
REQ-031 Reset asserted in any state, including READ_WAIT or RESP, SHALL immediately drop rsp_valid, discard the pending response, and restart the INIT sweep after release; no pre-reset data SHALL remain readable.

Verification
REQ-032 Release reset -> init_done=0 for 64 cycles, =1 on cycle 64; read addr 5 -> rsp_data=0, rsp_write=0, rd_count=1.
REQ-033 Write addr 63 data 512'hA5 then write addr 0 data 512'h3C, read 63 then 0 -> responses 512'hA5 then 512'h3C; write ack 1 cycle and read data 2 cycles after accept; wr_count=2, rd_count=2.
REQ-034 Read with rsp_ready held 0 for 10 cycles -> rsp_valid=1 and rsp_data stable for all 10 cycles, req_ready=0 throughout; IDLE on the cycle after rsp_ready=1.
REQ-035 Write addr 7 = 512'h1, then assert rst_n=0 during READ_WAIT of a read of addr 7 -> rsp_valid=0 at once; after re-init, read addr 7 returns 0 and both counters are 0.
REQ-036 req_valid=1 held during INIT -> no acceptance, counters 0; first acceptance on the first IDLE cycle.
REQ-037 65537 accepted reads -> rd_count=16'hFFFF with no wrap; wr_count unchanged.

Source files
------------

// File: rtl/local_mem_if.sv
// rtl/local_mem_if.sv - request/response bus between a requester and the local line store
interface local_mem_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 512
);
    logic                  req_valid;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_ready;
    logic                  rsp_valid;
    logic                  rsp_write;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_ready;

    modport master (
        output req_valid, req_write, req_addr, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_write, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_write, rsp_data
    );
endinterface

// File: rtl/local_mem_responder.sv
// rtl/local_mem_responder.sv - zero-initialised cache-line store answering one request at a time
module local_mem_responder #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    local_mem_if.slave  bus,
    output logic        init_done,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    localparam int LINES = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_READ_WAIT,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] line_cnt_q;
    logic [15:0]           rd_cnt_q;
    logic [15:0]           wr_cnt_q;
    logic                  rsp_write_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] mem [LINES];

    logic                  accept;
    logic                  rd_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        rd_en     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = line_cnt_q;
        mem_wdata = '0;
        unique case (state_q)
            S_INIT: begin
                // Sweep writes zero to one line per cycle; leave after the last line.
                mem_we = 1'b1;
                if (line_cnt_q == ADDR_WIDTH'(LINES - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (bus.req_write) begin
                        mem_we    = 1'b1;
                        mem_waddr = bus.req_addr;
                        mem_wdata = bus.req_data;
                        state_d   = S_RESP;
                    end else begin
                        rd_en   = 1'b1;
                        state_d = S_READ_WAIT;
                    end
                end
            end
            S_READ_WAIT: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt_q <= '0;
        end else if (state_q == S_INIT) begin
            line_cnt_q <= line_cnt_q + ADDR_WIDTH'(1);
        end
    end

    // Storage is not reset: the INIT sweep is what clears it after every reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_en) begin
            rd_data_q <= mem[bus.req_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_write_q <= 1'b0;
            rsp_data_q  <= '0;
        end else if (accept) begin
            rsp_write_q <= bus.req_write;
            rsp_data_q  <= '0;
        end else if (state_q == S_READ_WAIT) begin
            rsp_data_q  <= rd_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (accept && !bus.req_write && rd_cnt_q != 16'hFFFF) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (accept && bus.req_write && wr_cnt_q != 16'hFFFF) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_data  = rsp_data_q;
    assign init_done     = (state_q != S_INIT);
    assign rd_count      = rd_cnt_q;
    assign wr_count      = wr_cnt_q;
endmodule

// File: tb/tb_local_mem_responder.sv
// tb/tb_local_mem_responder.sv - directed self-checking bench for local_mem_responder
module tb_local_mem_responder;
    localparam int AW = 6;
    localparam int DW = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_rd = 0;
    int exp_wr = 0;

    local_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    local_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .init_done (init_done),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_rd_count"}, DW'(rd_count), DW'(exp_rd));
        check_eq({tag, "_wr_count"}, DW'(wr_count), DW'(exp_wr));
    endtask

    task automatic wait_init;
        for (int i = 1; i <= 64; i++) begin
            tick;
            check_eq("init_done_rise", DW'(init_done), DW'(i == 64));
        end
    endtask

    // One complete transaction; hold = extra cycles rsp_ready stays low once rsp_valid is up.
    task automatic xact(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp, input int hold);
        int lat;
        int guard;
        logic [DW-1:0] want;
        want  = w ? '0 : exp;
        guard = 0;
        while (!bus.req_ready && guard < 200) begin
            tick;
            guard++;
        end
        check_eq("idle_ready", DW'(bus.req_ready), DW'(1));
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_data  = d;
        tick;
        if (w) begin
            if (exp_wr < 65535) exp_wr++;
        end else begin
            if (exp_rd < 65535) exp_rd++;
        end
        bus.req_valid = 1'b0;
        bus.req_write = ~w;
        bus.req_addr  = ~a;
        bus.req_data  = ~d;
        check_counts("accept");
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            check_eq("busy_ready", DW'(bus.req_ready), DW'(0));
            tick;
            lat++;
        end
        check_eq("rsp_latency", DW'(lat), w ? DW'(1) : DW'(2));
        for (int h = 0; h <= hold; h++) begin
            check_eq("rsp_valid", DW'(bus.rsp_valid), DW'(1));
            check_eq("rsp_write", DW'(bus.rsp_write), DW'(w));
            check_eq("rsp_data", bus.rsp_data, want);
            check_eq("resp_ready", DW'(bus.req_ready), DW'(0));
            if (h < hold) tick;
        end
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        check_eq("after_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        check_eq("after_rsp_ready", DW'(bus.req_ready), DW'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_init_done"}, DW'(init_done), DW'(0));
        check_eq({tag, "_req_ready"}, DW'(bus.req_ready), DW'(0));
        check_eq({tag, "_rsp_valid"}, DW'(bus.rsp_valid), DW'(0));
        check_eq({tag, "_rsp_write"}, DW'(bus.rsp_write), DW'(0));
        check_eq({tag, "_rsp_data"}, bus.rsp_data, '0);
        check_eq({tag, "_rd_count"}, DW'(rd_count), DW'(0));
        check_eq({tag, "_wr_count"}, DW'(wr_count), DW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] pat;
        pat = {16{32'hDEADBEEF}};
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 6'd5;
        bus.req_data  = '1;
        bus.rsp_ready = 1'b0;

        repeat (3) tick;
        check_reset_outputs("reset");

        // req_valid held through INIT: accepted only on the first IDLE edge
        rst_n = 1'b1;
        wait_init;
        check_eq("first_idle_ready", DW'(bus.req_ready), DW'(1));
        check_counts("init_held");
        tick;
        exp_rd = 1;
        bus.req_valid = 1'b0;
        check_counts("first_accept");
        check_eq("rw_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        check_eq("rw_req_ready", DW'(bus.req_ready), DW'(0));
        tick;
        check_eq("rd5_rsp_valid", DW'(bus.rsp_valid), DW'(1));
        check_eq("rd5_rsp_write", DW'(bus.rsp_write), DW'(0));
        check_eq("rd5_rsp_data", bus.rsp_data, '0);
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        check_eq("rd5_done_valid", DW'(bus.rsp_valid), DW'(0));
        check_eq("rd5_done_ready", DW'(bus.req_ready), DW'(1));

        xact(1'b1, 6'd63, 512'hA5, '0, 0);
        xact(1'b1, 6'd0,  512'h3C, '0, 0);
        xact(1'b0, 6'd63, '0, 512'hA5, 0);
        xact(1'b0, 6'd0,  '0, 512'h3C, 0);
        check_counts("edge_lines");
        xact(1'b1, 6'd31, pat, '0, 0);
        xact(1'b0, 6'd31, '0, pat, 0);
        xact(1'b0, 6'd30, '0, '0, 0);

        xact(1'b0, 6'd63, '0, 512'hA5, 10);

        // Reset while a write acknowledge is being presented
        xact(1'b1, 6'd7, 512'h1, '0, 0);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 6'd9;
        bus.req_data  = 512'h99;
        tick;
        bus.req_valid = 1'b0;
        check_eq("resp_before_rst", DW'(bus.rsp_valid), DW'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_in_resp");
        exp_rd = 0;
        exp_wr = 0;
        tick;
        rst_n = 1'b1;
        wait_init;

        // Reset while a read of line 7 sits in READ_WAIT
        xact(1'b1, 6'd7, 512'h1, '0, 0);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 6'd7;
        tick;
        bus.req_valid = 1'b0;
        check_eq("read_wait_valid", DW'(bus.rsp_valid), DW'(0));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_in_rdwait");
        exp_rd = 0;
        exp_wr = 0;
        tick;
        rst_n = 1'b1;
        wait_init;
        check_counts("reinit");
        xact(1'b0, 6'd7, '0, '0, 0);
        xact(1'b0, 6'd63, '0, '0, 0);
        xact(1'b0, 6'd9, '0, '0, 0);

        // Saturation: preload the read counter close to its limit
        tick;
        force dut.rd_cnt_q = 16'hFFFD;
        #1;
        release dut.rd_cnt_q;
        exp_rd = 65533;
        xact(1'b0, 6'd1, '0, '0, 0);
        check_eq("sat_fffe", DW'(rd_count), DW'(16'hFFFE));
        xact(1'b0, 6'd2, '0, '0, 0);
        check_eq("sat_ffff", DW'(rd_count), DW'(16'hFFFF));
        xact(1'b0, 6'd3, '0, '0, 0);
        check_eq("sat_hold", DW'(rd_count), DW'(16'hFFFF));
        check_eq("sat_wr_count", DW'(wr_count), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
